// File: rtl/hc595_chain_ctrl_if.sv
// Handshake and board-pin bundle for the 74HC595 chain driver.
// W is the frame width and must equal 8*CHIP_NUM of the attached controller.
interface hc595_chain_ctrl_if #(
    parameter int W = 16
);
    logic [W-1:0] data_in;
    logic         load;
    logic         en;
    logic         ready;
    logic         done;
    logic         ds;
    logic         shcp;
    logic         stcp;
    logic         oe;

    modport master (
        output data_in, load, en,
        input  ready, done, ds, shcp, stcp, oe
    );

    modport slave (
        input  data_in, load, en,
        output ready, done, ds, shcp, stcp, oe
    );
endinterface

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy-chain of CHIP_NUM 74HC595s: accepts a frame on load/ready,
// shifts it out on ds/shcp at DIV clocks per bit, then latches it with one stcp pulse.
module hc595_chain_ctrl #(
    parameter int CHIP_NUM  = 2,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    hc595_chain_ctrl_if.slave   bus
);
    localparam int W     = 8 * CHIP_NUM;
    localparam int PH_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(W);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("hc595_chain_ctrl: DIV must be even and >= 2");
    end
    if (CHIP_NUM < 1 || CHIP_NUM > 8) begin : g_bad_chip_num
        $error("hc595_chain_ctrl: CHIP_NUM must be within 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [PH_W-1:0]  phase_q,  phase_d;
    logic [BIT_W-1:0] bit_q,    bit_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic             ds_q,     ds_d;
    logic             shcp_q,   shcp_d;
    logic             stcp_q,   stcp_d;
    logic             done_q,   done_d;
    logic             ready_q,  ready_d;
    logic             oe_q;
    logic             cur_bit_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        ds_d     = ds_q;
        shcp_d   = shcp_q;
        stcp_d   = stcp_q;
        done_d   = 1'b0;

        if (MSB_FIRST) begin
            cur_bit_s = shadow_q[BIT_LAST - bit_q];
        end else begin
            cur_bit_s = shadow_q[bit_q];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.load && ready_q) begin
                    shadow_d = bus.data_in;
                    phase_d  = '0;
                    bit_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // ds changes with shcp low; shcp rises mid-eye so the chip samples a settled bit.
                if (phase_q == '0) begin
                    ds_d   = cur_bit_s;
                    shcp_d = 1'b0;
                end else if (phase_q == PH_HALF) begin
                    shcp_d = 1'b1;
                end else begin
                    shcp_d = shcp_q;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (phase_q == '0) begin
                    shcp_d  = 1'b0;
                    stcp_d  = 1'b1;
                    phase_d = phase_q + PH_W'(1);
                end else if (phase_q == PH_HALF) begin
                    stcp_d  = 1'b0;
                    done_d  = 1'b1;
                    phase_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                bit_d   = '0;
                shcp_d  = 1'b0;
                stcp_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; a reset mid-frame drops the frame without pulsing stcp.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            ds_q     <= 1'b0;
            shcp_q   <= 1'b0;
            stcp_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            oe_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            ds_q     <= ds_d;
            shcp_q   <= shcp_d;
            stcp_q   <= stcp_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            oe_q     <= ~bus.en;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.ds    = ds_q;
    assign bus.shcp  = shcp_q;
    assign bus.stcp  = stcp_q;
    assign bus.oe    = oe_q;
endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl: three configurations, cycle-exact waveform checks.
module tb_hc595_chain_ctrl;
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    always #5 sys_clk = ~sys_clk;

    hc595_chain_ctrl_if #(.W(16)) b0 ();
    hc595_chain_ctrl_if #(.W(8))  b1 ();
    hc595_chain_ctrl_if #(.W(32)) b2 ();

    hc595_chain_ctrl #(.CHIP_NUM(2), .DIV(4), .MSB_FIRST(1'b0)) u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b0.slave));
    hc595_chain_ctrl #(.CHIP_NUM(1), .DIV(2), .MSB_FIRST(1'b1)) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b1.slave));
    hc595_chain_ctrl #(.CHIP_NUM(4), .DIV(4), .MSB_FIRST(1'b0)) u2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b2.slave));

    int   n_checks = 0;
    int   n_errs   = 0;
    int   sel      = 0;
    int   stcp_cnt0 = 0;
    logic o_ds, o_shcp, o_stcp, o_done, o_ready, o_oe;

    always @(posedge b0.stcp) stcp_cnt0 <= stcp_cnt0 + 1;

    always_comb begin
        case (sel)
            1:       {o_ds, o_shcp, o_stcp, o_done, o_ready, o_oe} = {b1.ds, b1.shcp, b1.stcp, b1.done, b1.ready, b1.oe};
            2:       {o_ds, o_shcp, o_stcp, o_done, o_ready, o_oe} = {b2.ds, b2.shcp, b2.stcp, b2.done, b2.ready, b2.oe};
            default: {o_ds, o_shcp, o_stcp, o_done, o_ready, o_oe} = {b0.ds, b0.shcp, b0.stcp, b0.done, b0.ready, b0.oe};
        endcase
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic [31:0] d, input logic ld, input logic e);
        case (which)
            1:       begin b1.data_in = d[7:0];  b1.load = ld; b1.en = e; end
            2:       begin b2.data_in = d;       b2.load = ld; b2.en = e; end
            default: begin b0.data_in = d[15:0]; b0.load = ld; b0.en = e; end
        endcase
    endtask

    // Runs one frame starting at a negedge; compares every output against the timing formulas.
    task automatic frame(input int which, input logic [31:0] data, input int w, input int div,
                         input bit msb, input bit hold, input int inj_at, input int en_at,
                         input string tag, output logic [31:0] seq, output int done_at);
        logic [255:0] ds_o, ds_e, sh_o, sh_e, st_o, st_e, dn_o, dn_e, rd_o, rd_e, oe_o, oe_e;
        int L, idx;
        logic ld, e;
        logic [31:0] d;
        L = w * div + div / 2 + 1;
        seq = '0; done_at = -1;
        ds_o = '0; ds_e = '0; sh_o = '0; sh_e = '0; st_o = '0; st_e = '0;
        dn_o = '0; dn_e = '0; rd_o = '0; rd_e = '0; oe_o = '0; oe_e = '0;
        sel = which;
        drive(which, data, 1'b1, 1'b0);
        @(posedge sys_clk);
        for (int n = 0; n <= L; n++) begin
            @(negedge sys_clk);
            if (n >= 1) ds_o[n] = o_ds;
            sh_o[n] = o_shcp; st_o[n] = o_stcp; dn_o[n] = o_done; rd_o[n] = o_ready; oe_o[n] = o_oe;
            if (o_done === 1'b1 && done_at < 0) done_at = n;
            if (n >= 1 && ((n - 1) % div) == 0 && ((n - 1) / div) < w) seq[(n - 1) / div] = o_ds;
            idx = (n - 1) / div;
            if (idx > w - 1) idx = w - 1;
            if (n >= 1) ds_e[n] = msb ? data[w - 1 - idx] : data[idx];
            sh_e[n] = (n >= 1 && n <= w * div && ((n - 1) % div) >= div / 2);
            st_e[n] = (n > w * div && n <= w * div + div / 2);
            dn_e[n] = (n == L);
            rd_e[n] = (n == L);
            oe_e[n] = !(en_at >= 0 && n > en_at && n <= en_at + 3);
            ld = hold || (inj_at >= 0 && n == inj_at);
            d  = (inj_at >= 0 && n >= inj_at) ? ~data : data;
            e  = (en_at >= 0 && n >= en_at && n < en_at + 3);
            drive(which, d, ld, e);
        end
        chk({tag, "_ds"},    ds_o, ds_e);
        chk({tag, "_shcp"},  sh_o, sh_e);
        chk({tag, "_stcp"},  st_o, st_e);
        chk({tag, "_done"},  dn_o, dn_e);
        chk({tag, "_ready"}, rd_o, rd_e);
        chk({tag, "_oe"},    oe_o, oe_e);
    endtask

    initial begin
        logic [31:0] seq;
        int done_at, bad, c0;
        drive(0, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 1'b0, 1'b0);
        drive(2, 32'h0, 1'b0, 1'b0);
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_state", {b0.ready, b0.ds, b0.shcp, b0.stcp, b0.done, b0.oe}, 6'b100001);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // oe follows en with one cycle of latency in IDLE
        b0.en = 1'b1;
        #1 chk("oe_idle_hold", b0.oe, 1'b1);
        @(negedge sys_clk);
        chk("oe_idle_on", b0.oe, 1'b0);
        b0.en = 1'b0;
        @(negedge sys_clk);
        chk("oe_idle_off", b0.oe, 1'b1);

        // Default configuration, LSB first
        frame(0, 32'h0000_A5C3, 16, 4, 1'b0, 1'b0, -1, -1, "def", seq, done_at);
        chk("def_seq", seq, 32'h0000_A5C3);
        chk("def_latency", done_at, 67);

        // CHIP_NUM=1, DIV=2, MSB first: 8'h81 shifts out 1,0,0,0,0,0,0,1
        frame(1, 32'h0000_0081, 8, 2, 1'b1, 1'b0, -1, -1, "msb", seq, done_at);
        chk("msb_seq", seq, 32'h0000_0081);
        chk("msb_latency", done_at, 18);

        // load held high: back-to-back frames every 68 cycles
        frame(0, 32'h0000_1234, 16, 4, 1'b0, 1'b1, -1, -1, "hold1", seq, done_at);
        chk("hold1_latency", done_at, 67);
        frame(0, 32'h0000_1234, 16, 4, 1'b0, 1'b1, -1, -1, "hold2", seq, done_at);
        drive(0, 32'h0000_1234, 1'b0, 1'b0);
        chk("hold2_seq", seq, 32'h0000_1234);
        chk("hold2_latency", done_at, 67);

        // Mid-frame data change and load pulse are ignored; en toggled mid-frame
        frame(0, 32'h0000_5A0F, 16, 4, 1'b0, 1'b0, 20, 10, "inj", seq, done_at);
        chk("inj_seq", seq, 32'h0000_5A0F);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (!(o_ready === 1'b1 && o_shcp === 1'b0 && o_stcp === 1'b0)) bad++;
        end
        chk("no_second_frame", bad, 0);

        // Reset asserted during bit 7 (shcp high, ds=1 for C3)
        sel = 0;
        drive(0, 32'h0000_A5C3, 1'b1, 1'b1);
        @(posedge sys_clk);
        for (int n = 0; n < 32; n++) begin
            @(negedge sys_clk);
            if (n == 0) drive(0, 32'h0000_A5C3, 1'b0, 1'b1);
        end
        chk("pre_rst", {b0.ds, b0.shcp, b0.oe}, 3'b110);
        c0 = stcp_cnt0;
        sys_rst_n = 1'b0;
        #1 chk("mid_rst", {b0.ready, b0.ds, b0.shcp, b0.stcp, b0.done, b0.oe}, 6'b100001);
        drive(0, 32'h0000_3C96, 1'b0, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (70) @(negedge sys_clk);
        chk("rst_no_latch", stcp_cnt0 - c0, 0);
        chk("rst_idle", {b0.ready, b0.shcp}, 2'b10);
        frame(0, 32'h0000_3C96, 16, 4, 1'b0, 1'b0, -1, -1, "post_rst", seq, done_at);
        chk("post_rst_seq", seq, 32'h0000_3C96);
        chk("post_rst_latency", done_at, 67);

        // CHIP_NUM=4: only bit 0 is high
        frame(2, 32'h0000_0001, 32, 4, 1'b0, 1'b0, -1, -1, "c4", seq, done_at);
        chk("c4_seq", seq, 32'h0000_0001);
        chk("c4_latency", done_at, 131);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/hc595_chain_ctrl.md
# hc595_chain_ctrl

Parametrised serial driver for a daisy-chain of CHIP_NUM 74HC595 shift registers, replacing the fixed two-chip free-running driver in the display path. A parallel word is accepted through a ready/load handshake, shifted out on ds/shcp at a programmable bit rate, and committed to the chip outputs with a single stcp pulse, followed by a done strobe. Upstream logic, such as a digit scanner or LED/relay bank controller, decides when and how often to refresh. The module sits between that logic and the board pins.

## Interface
- CHIP_NUM, 2, number of chained 595s; frame width W = 8*CHIP_NUM (1..8 supported)
- DIV, 4, sys_clk cycles per serial bit; even, >= 2; any other value is an elaboration error
- MSB_FIRST, 0, 0: data_in[0] shifted first; 1: data_in[W-1] shifted first
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- data_in  in  W  frame to send; sampled only on the accepting edge
- load  in  1  request; accepted on an edge where load=1 and ready=1
- en  in  1  output enable request for the chips
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when stcp falls at the end of a frame
- ds  out  1  595 serial data
- shcp  out  1  595 shift clock
- stcp  out  1  595 storage (latch) clock
- oe  out  1  595 active-low output enable; registered ~en

## Operation
- FSM states: IDLE -> SHIFT -> LATCH -> IDLE.
  - IDLE: ready=1. On accept, data_in is captured into a W-bit shadow register, bit index is set to 0, and the state moves to SHIFT.
  - SHIFT: a phase counter runs 0..DIV-1.
    - Phase 0: ds <= bit k and shcp <= 0.
    - Phase DIV/2: shcp <= 1.
    - At phase DIV-1 of bit W-1, the state moves to LATCH.
  - LATCH: on the first edge, shcp <= 0 and stcp <= 1. stcp stays high for DIV/2 cycles, then stcp <= 0, done <= 1, ready <= 1, and the state returns to IDLE.
- Bit k = shadow[k] when MSB_FIRST=0, and shadow[W-1-k] when MSB_FIRST=1. The first bit shifted ends in the far chip's Q7.
- load while ready=0 is ignored. data_in changes during a frame have no effect.
- ds holds the last bit shifted after a frame. shcp and stcp are low in IDLE.
- oe <= ~en every cycle, independent of the FSM.
- Reset, at any time including mid-frame:
  - State IDLE, counters 0, shadow 0.
  - ds=0, shcp=0, stcp=0, done=0, ready=1, oe=1.
  - A partial frame is never latched, because stcp is not pulsed. The chips keep their previous outputs.

## Timing
- Reference point: accept edge T0, the edge on which load=1 and ready=1.
- ready falls at T0.
- Bit k appears on ds at T0+1+k*DIV and is held for DIV cycles.
- shcp rises at T0+1+k*DIV+DIV/2 and falls at T0+1+(k+1)*DIV. The rising edge sits mid-eye.
- stcp rises at T0+1+W*DIV, the same edge as the last shcp fall.
- stcp falls at T0+1+W*DIV+DIV/2. done is high for that one cycle, and ready is high from that edge.
- Accept-to-done latency is W*DIV+DIV/2+1 cycles: 67 for CHIP_NUM=2, DIV=4.
- Earliest next accept is one edge after done. With load held high, the frame period is W*DIV+DIV/2+2 cycles (68 in the default case).
- DIV=2: shcp and stcp each high for exactly 1 cycle.
- oe follows en with 1-cycle latency.

## Test plan
- Defaults, data_in=16'hA5C3, load pulsed once:
  - ds bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first).
  - 16 shcp rising edges, each 2 cycles after the ds change.
  - One stcp pulse of 2 cycles; done exactly 67 cycles after accept.
- MSB_FIRST=1, CHIP_NUM=1, DIV=2, data_in=8'h81:
  - ds sequence 1,0,0,0,0,0,0,1; 8 shcp pulses, each high 1 cycle.
  - stcp high 1 cycle; done 18 cycles after accept.
- load held high, defaults:
  - Frames repeat every 68 cycles.
  - Exactly one stcp pulse per frame; ready is low throughout each frame.
- data_in changed and load pulsed mid-frame:
  - The load is ignored and the shifted bits match the originally captured word.
  - No second frame starts.
- sys_rst_n asserted at bit 7 of a frame:
  - ds, shcp, stcp and done are 0 and oe=1 immediately, with no stcp pulse.
  - After release, ready=1 and a new load runs a complete, correct frame.
- en toggled 0->1->0 in IDLE and mid-frame:
  - oe=1, 0, 1, each following en with one cycle delay.
  - Shift timing is unaffected.
- CHIP_NUM=4, data_in=32'h0000_0001:
  - ds high only for bit 0; 32 shcp pulses; done at 131 cycles.
